// File: rtl/race_pkg.sv
// rtl/race_pkg.sv - scan-code constants and frame helpers shared by the PS/2 input stage
package race_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_P     = 8'h4D;

  localparam int FRAME_LEN = 11;

  // Frame layout, LSB first: start, 8 data bits, odd parity, stop.
  function automatic logic frame_ok(input logic [FRAME_LEN-1:0] f);
    return (f[0] == 1'b0) && f[FRAME_LEN-1] && (^f[FRAME_LEN-2:1]);
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver: synchronizer, clock filter, shifter, checker, watchdog
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       code_valid_o,
  output logic [7:0] scan_code_o,
  output logic       frame_err_o
);
  import race_pkg::*;

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam int BCW = $clog2(FRAME_LEN);

  logic [1:0]           clk_sync_q, data_sync_q;
  logic                 filt_q;
  logic [FCW-1:0]       fcnt_q;
  logic [FRAME_LEN-2:0] shreg_q;
  logic [BCW-1:0]       bit_cnt_q;
  logic [WDW-1:0]       wd_q;
  logic                 code_valid_q, frame_err_q;
  logic [7:0]           scan_code_q;

  logic                 clk_s, data_s, fall, last_bit, timeout;
  logic [FRAME_LEN-1:0] frame;

  assign clk_s    = clk_sync_q[1];
  assign data_s   = data_sync_q[1];
  assign fall     = filt_q & ~clk_s & (fcnt_q == FCW'(FILTER_LEN - 1));
  assign last_bit = (bit_cnt_q == BCW'(FRAME_LEN - 1));
  // The 11th bit is checked straight off the synchronizer so code_valid lands one cycle after fall.
  assign frame    = {data_s, shreg_q};
  // wd_q steps to TIMEOUT_CYCLES-1 on this edge; a simultaneous fall takes precedence.
  assign timeout  = ~fall & (bit_cnt_q != '0) & (wd_q == WDW'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      filt_q       <= 1'b1;
      fcnt_q       <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      wd_q         <= '0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      scan_code_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};

      if (clk_s == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_q <= clk_s;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end

      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (fall) begin
        wd_q    <= '0;
        shreg_q <= {data_s, shreg_q[FRAME_LEN-2:1]};
        if (last_bit) begin
          bit_cnt_q <= '0;
          if (frame_ok(frame)) begin
            code_valid_q <= 1'b1;
            scan_code_q  <= frame[8:1];
          end else begin
            frame_err_q <= 1'b1;
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end else if (timeout) begin
        bit_cnt_q   <= '0;
        wd_q        <= '0;
        frame_err_q <= 1'b1;
      end else if (bit_cnt_q != '0) begin
        wd_q <= wd_q + 1'b1;
      end else begin
        wd_q <= '0;
      end
    end
  end

  assign code_valid_o = code_valid_q;
  assign scan_code_o  = scan_code_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - make/break decoder producing held steering keys and pause toggle
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       left_key,
  output logic       right_key,
  output logic       pause,
  output logic       code_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);
  import race_pkg::*;

  logic ext_q, brk_q;
  logic left_arrow_q, a_q, right_arrow_q, d_q, p_q, pause_q;
  logic make;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .code_valid_o(code_valid),
    .scan_code_o (scan_code),
    .frame_err_o (frame_err)
  );

  assign make = ~brk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      left_arrow_q  <= 1'b0;
      a_q           <= 1'b0;
      right_arrow_q <= 1'b0;
      d_q           <= 1'b0;
      p_q           <= 1'b0;
      pause_q       <= 1'b0;
    end else if (frame_err) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (code_valid) begin
      case (scan_code)
        SC_EXT: ext_q <= 1'b1;
        SC_BRK: brk_q <= 1'b1;
        default: begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (ext_q && scan_code == SC_LEFT)   left_arrow_q  <= make;
          if (ext_q && scan_code == SC_RIGHT)  right_arrow_q <= make;
          if (!ext_q && scan_code == SC_A)     a_q           <= make;
          if (!ext_q && scan_code == SC_D)     d_q           <= make;
          // Typematic repeats of P arrive with p_q already set and must not re-toggle.
          if (!ext_q && scan_code == SC_P) begin
            if (make && !p_q) pause_q <= ~pause_q;
            p_q <= make;
          end
        end
      endcase
    end
  end

  assign left_key  = left_arrow_q | a_q;
  assign right_key = right_arrow_q | d_q;
  assign pause     = pause_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - table, directed and randomized checks of ps2_key_decoder
module tb_ps2_key_decoder;
  localparam int FL   = 4;
  localparam int TO   = 100;
  localparam int HALF = 12;

  typedef struct {
    logic [7:0] code;
    bit         bad;
    bit         l;
    bit         r;
    bit         p;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       left_key, right_key, pause, code_valid, frame_err;
  logic [7:0] scan_code;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cv_cnt = 0, fe_cnt = 0, cv_cyc = 0, fe_cyc = 0, drive_cyc = 0;
  logic lk_at = 1'b0, lk_after = 1'b0, cap = 1'b0;

  bit         held [512];
  bit         m_ext, m_brk, m_pause;
  logic [7:0] m_scan;

  vec_t vecs [28];

  always #5 clk = ~clk;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .left_key  (left_key),
    .right_key (right_key),
    .pause     (pause),
    .code_valid(code_valid),
    .scan_code (scan_code),
    .frame_err (frame_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (code_valid) begin
      cv_cnt <= cv_cnt + 1;
      cv_cyc <= cyc;
      lk_at  <= left_key;
    end
    if (frame_err) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    cap <= code_valid;
    if (cap) lk_after <= left_key;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (held[i]) held[i] = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_pause = 1'b0;
    m_scan = 8'h00;
  endtask

  // Keyboard state as a set of held {ext,code} keys; outputs read a few of them.
  task automatic model_frame(input logic [7:0] code, input bit ok);
    logic [8:0] key;
    if (!ok) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      return;
    end
    m_scan = code;
    if (code == 8'hE0) m_ext = 1'b1;
    else if (code == 8'hF0) m_brk = 1'b1;
    else begin
      key = {m_ext, code};
      if (!m_brk) begin
        if (key == 9'h04D && !held[key]) m_pause = !m_pause;
        held[key] = 1'b1;
      end else begin
        held[key] = 1'b0;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  function automatic bit m_left();
    return held[9'h16B] | held[9'h01C];
  endfunction

  function automatic bit m_right();
    return held[9'h174] | held[9'h023];
  endfunction

  task automatic send_frame(input logic [7:0] code, input bit bad, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^code) ^ bad, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      drive_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic model_checked_frame(input logic [7:0] code, input bit bad, input string tag);
    int cv0, fe0;
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    send_frame(code, bad, 11);
    model_frame(code, !bad);
    chk({tag, "_cv"}, cv_cnt - cv0, bad ? 0 : 1);
    chk({tag, "_fe"}, fe_cnt - fe0, bad ? 1 : 0);
    chk({tag, "_scan"}, scan_code, m_scan);
    chk({tag, "_left"}, left_key, m_left());
    chk({tag, "_right"}, right_key, m_right());
    chk({tag, "_pause"}, pause, m_pause);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    int cv0, fe0;
    bit prev_l;
    logic [7:0] prev_scan;
    logic [7:0] pool [7];
    logic [7:0] code;
    bit bad;
    int pick;

    vecs = '{
      '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0}, '{8'h6B, 1'b0, 1'b1, 1'b0, 1'b0},
      '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0}, '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0},
      '{8'h6B, 1'b0, 1'b0, 1'b0, 1'b0}, '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0},
      '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0}, '{8'h74, 1'b0, 1'b1, 1'b1, 1'b0},
      '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0}, '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0},
      '{8'hE0, 1'b0, 1'b0, 1'b1, 1'b0}, '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{8'h74, 1'b0, 1'b0, 1'b0, 1'b0}, '{8'h4D, 1'b0, 1'b0, 1'b0, 1'b1},
      '{8'h4D, 1'b0, 1'b0, 1'b0, 1'b1}, '{8'h4D, 1'b0, 1'b0, 1'b0, 1'b1},
      '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1}, '{8'h4D, 1'b0, 1'b0, 1'b0, 1'b1},
      '{8'h4D, 1'b0, 1'b0, 1'b0, 1'b0}, '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'h4D, 1'b0, 1'b0, 1'b0, 1'b0}, '{8'h6B, 1'b1, 1'b0, 1'b0, 1'b0},
      '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0}, '{8'h6B, 1'b1, 1'b0, 1'b0, 1'b0},
      '{8'h6B, 1'b0, 1'b0, 1'b0, 1'b0}, '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'h6B, 1'b0, 1'b1, 1'b0, 1'b0}, '{8'h23, 1'b0, 1'b1, 1'b1, 1'b0}
    };
    pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h1C, 8'h23, 8'h4D};

    model_reset();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_left", left_key, 0);
    chk("rst_right", right_key, 0);
    chk("rst_pause", pause, 0);
    chk("rst_scan", scan_code, 0);
    chk("rst_cv", code_valid, 0);
    chk("rst_fe", frame_err, 0);

    prev_l = 1'b0;
    prev_scan = 8'h00;
    for (int i = 0; i < 28; i++) begin
      cv0 = cv_cnt;
      fe0 = fe_cnt;
      send_frame(vecs[i].code, vecs[i].bad, 11);
      model_frame(vecs[i].code, !vecs[i].bad);
      if (!vecs[i].bad) prev_scan = vecs[i].code;
      chk($sformatf("vec%0d_cv", i), cv_cnt - cv0, vecs[i].bad ? 0 : 1);
      chk($sformatf("vec%0d_fe", i), fe_cnt - fe0, vecs[i].bad ? 1 : 0);
      chk($sformatf("vec%0d_scan", i), scan_code, prev_scan);
      chk($sformatf("vec%0d_left", i), left_key, vecs[i].l);
      chk($sformatf("vec%0d_right", i), right_key, vecs[i].r);
      chk($sformatf("vec%0d_pause", i), pause, vecs[i].p);
      if (!vecs[i].bad) begin
        chk($sformatf("vec%0d_cv_latency", i), cv_cyc, drive_cyc + FL + 2);
        chk($sformatf("vec%0d_left_at_cv", i), lk_at, prev_l);
        chk($sformatf("vec%0d_left_after_cv", i), lk_after, vecs[i].l);
      end
      prev_l = vecs[i].l;
    end

    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 9);
      code = (pick < 7) ? pool[pick] : 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0);
      model_checked_frame(code, bad, $sformatf("rnd%0d", n));
    end

    cv0 = cv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h23, 1'b0, 5);
    for (int k = 0; k < TO + 50 && fe_cnt == fe0; k++) @(negedge clk);
    @(negedge clk);
    chk("timeout_fe_count", fe_cnt - fe0, 1);
    chk("timeout_fe_cycle", fe_cyc, drive_cyc + FL + 1 + TO);
    chk("timeout_no_cv", cv_cnt - cv0, 0);
    model_frame(8'h00, 1'b0);
    model_checked_frame(8'h23, 1'b0, "after_timeout");
    chk("after_timeout_right_const", right_key, 1);
    chk("after_timeout_scan_const", scan_code, 8'h23);

    fe0 = fe_cnt;
    send_frame(8'h74, 1'b0, 6);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_fe_during", fe_cnt - fe0, 0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_left", left_key, 0);
    chk("midrst_right", right_key, 0);
    chk("midrst_pause", pause, 0);
    chk("midrst_scan", scan_code, 0);
    repeat (TO + 20) @(negedge clk);
    chk("midrst_no_timeout", fe_cnt - fe0, 0);
    model_checked_frame(8'h1C, 1'b0, "after_reset");
    chk("after_reset_left_const", left_key, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
